// File: rtl/hdb3_decode.sv
// HDB3 receive decoder: bipolar BP/BN pair to NRZ with B/V mark removal and line-code error flagging.
// Define HDB3_DEC_ERR_CNT_EN to add the saturating err_cnt output.
module hdb3_decode #(
    parameter int ZERO_RUN_MAX = 3,
    parameter int ERR_CNT_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_en,
    input  logic BP,
    input  logic BN,
    output logic data_m,
    output logic data_valid,
    output logic code_err
`ifdef HDB3_DEC_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_cnt
`endif
);
    localparam int ZW = $clog2(ZERO_RUN_MAX + 2);
    localparam logic [ZW-1:0] ZRUN_LIMIT = ZW'(ZERO_RUN_MAX);
    localparam logic [ZW-1:0] ZRUN_SAT   = ZW'(ZERO_RUN_MAX + 1);

    logic [3:0]    sr;
    logic [2:0]    fill;
    logic          seen;
    logic          last_pol;
    logic          last_vpol;
    logic          v_seen;
    logic [ZW-1:0] zrun;

    logic illegal;
    logic mark;
    logic pol;
    logic v;
    logic run_err;
    logic vv_err;
    logic err_any;

    always_comb begin
        illegal = BP & BN;
        mark    = BP ^ BN;
        pol     = BP;
        v       = mark & seen & (pol == last_pol);
        // The zero arriving now is the (ZERO_RUN_MAX+1)th; saturation keeps longer runs from re-flagging.
        run_err = ~mark & (zrun == ZRUN_LIMIT);
        vv_err  = v & v_seen & (pol == last_vpol);
        err_any = illegal | run_err | vv_err;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            data_m     <= 1'b0;
            data_valid <= 1'b0;
            code_err   <= 1'b0;
            sr         <= 4'd0;
            fill       <= 3'd0;
            seen       <= 1'b0;
            last_pol   <= 1'b0;
            last_vpol  <= 1'b0;
            v_seen     <= 1'b0;
            zrun       <= '0;
        end else if (bit_en) begin
            data_m     <= sr[3];
            // A V removes itself and the B three positions back still waiting in sr[2].
            sr         <= {sr[2] & ~v, sr[1], sr[0], mark & ~v};
            data_valid <= (fill == 3'd4);
            code_err   <= err_any;
            if (fill != 3'd4) begin
                fill <= fill + 3'd1;
            end
            if (mark) begin
                seen     <= 1'b1;
                last_pol <= pol;
                zrun     <= '0;
            end else if (zrun != ZRUN_SAT) begin
                zrun <= zrun + ZW'(1);
            end
            if (v) begin
                last_vpol <= pol;
                v_seen    <= 1'b1;
            end
        end else begin
            data_valid <= 1'b0;
            code_err   <= 1'b0;
        end
    end

`ifdef HDB3_DEC_ERR_CNT_EN
    always_ff @(posedge clk) begin
        if (rst_n) begin
            err_cnt <= '0;
        end else if (bit_en && err_any && !(&err_cnt)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hdb3_decode.sv
// Self-checking bench for hdb3_decode: directed HDB3 patterns plus randomized line symbols
// compared against a history-based reference model of the decode rules.
module tb_hdb3_decode;
    localparam int ZRM = 3;
    localparam int CW  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic bit_en = 1'b0;
    logic BP = 1'b0;
    logic BN = 1'b0;
    logic data_m;
    logic data_valid;
    logic code_err;
`ifdef HDB3_DEC_ERR_CNT_EN
    logic [CW-1:0] err_cnt;
`endif

    hdb3_decode #(.ZERO_RUN_MAX(ZRM), .ERR_CNT_W(CW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bit_en(bit_en),
        .BP(BP),
        .BN(BN),
        .data_m(data_m),
        .data_valid(data_valid),
        .code_err(code_err)
`ifdef HDB3_DEC_ERR_CNT_EN
        ,
        .err_cnt(err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // symbols since last reset: 0 zero, 1 plus mark, 2 minus mark, 3 illegal
    int   sym_q[$];
    bit   v_q[$];
    int   err_tot;
    logic exp_dm;

    logic [63:0] got_bits;
    int          got_n;
    int          got_errs;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit is_mark(input int s);
        return (s == 1) || (s == 2);
    endfunction

    task automatic model_step(input int s, output bit e_dv, output bit e_err);
        bit mk, pol, found, lp, v, run_err, vv, done;
        int cnt, n, k;
        mk = is_mark(s);
        pol = (s == 1);
        found = 0;
        lp = 0;
        for (int i = sym_q.size() - 1; i >= 0; i--) begin
            if (!found && is_mark(sym_q[i])) begin
                found = 1;
                lp = (sym_q[i] == 1);
            end
        end
        v = mk && found && (lp == pol);
        cnt = 0;
        if (!mk) begin
            cnt = 1;
            done = 0;
            for (int i = sym_q.size() - 1; i >= 0; i--) begin
                if (!done) begin
                    if (is_mark(sym_q[i])) done = 1;
                    else cnt++;
                end
            end
        end
        run_err = !mk && (cnt == ZRM + 1);
        vv = 0;
        if (v) begin
            done = 0;
            for (int i = v_q.size() - 1; i >= 0; i--) begin
                if (!done && v_q[i]) begin
                    done = 1;
                    vv = ((sym_q[i] == 1) == pol);
                end
            end
        end
        sym_q.push_back(s);
        v_q.push_back(v);
        e_err = (s == 3) || run_err || vv;
        if (e_err) err_tot++;
        n = sym_q.size();
        e_dv = (n >= 5);
        if (n >= 5) begin
            k = n - 5;
            exp_dm = is_mark(sym_q[k]) && !v_q[k] && !v_q[k + 3];
        end else begin
            exp_dm = 1'b0;
        end
    endtask

    task automatic check_cnt(input string tag);
`ifdef HDB3_DEC_ERR_CNT_EN
        check(tag, 64'(err_cnt), 64'((err_tot > 3) ? 3 : err_tot));
`endif
    endtask

    task automatic drive(input bit en, input int s);
        bit e_dv, e_err;
        bit_en = en;
        BP = (s == 1) || (s == 3);
        BN = (s == 2) || (s == 3);
        @(posedge clk);
        #1;
        e_dv = 0;
        e_err = 0;
        if (en) model_step(s, e_dv, e_err);
        check("data_valid", 64'(data_valid), 64'(e_dv));
        check("code_err", 64'(code_err), 64'(e_err));
        check("data_m", 64'(data_m), 64'(exp_dm));
        check_cnt("err_cnt");
        if (en && data_valid && got_n < 64) begin
            got_bits = {got_bits[62:0], data_m};
            got_n++;
        end
        if (code_err) got_errs++;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        bit_en = 1'($urandom_range(0, 1));
        BP = 1'($urandom_range(0, 1));
        BN = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sym_q.delete();
        v_q.delete();
        err_tot = 0;
        exp_dm = 1'b0;
        check("rst_data_m", 64'(data_m), 64'd0);
        check("rst_data_valid", 64'(data_valid), 64'd0);
        check("rst_code_err", 64'(code_err), 64'd0);
        check_cnt("rst_err_cnt");
    endtask

    function automatic int char_sym(input byte c);
        case (c)
            "+": return 1;
            "-": return 2;
            "X": return 3;
            default: return 0;
        endcase
    endfunction

    task automatic run_seq(input string name, input string syms, input string bits, input int errs);
        logic [63:0] exp_bits;
        do_reset();
        got_bits = '0;
        got_n = 0;
        got_errs = 0;
        for (int i = 0; i < syms.len(); i++) drive(1'b1, char_sym(syms[i]));
        exp_bits = '0;
        for (int i = 0; i < bits.len(); i++) exp_bits = {exp_bits[62:0], bits[i] == "1"};
        check({name, "_bits"}, got_bits, exp_bits);
        check({name, "_nbits"}, 64'(got_n), 64'(syms.len() - 4));
        check({name, "_errs"}, 64'(got_errs), 64'(errs));
    endtask

    initial begin
        got_bits = '0;
        got_n = 0;
        got_errs = 0;
        err_tot = 0;
        exp_dm = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        run_seq("alt", "+-+-+-+-+-", "111111", 0);
        run_seq("v000", "+000+-+-+-+-+", "100001111", 0);
        run_seq("b00v", "+000+-+-00-+-+-", "10000110000", 0);
        run_seq("illegal", "+-X+-+-+", "1101", 1);
        run_seq("zrun", "+00000-+-+", "100000", 1);
        run_seq("sat", "XXXXX-+-+", "00000", 5);
        check_cnt("sat_err_cnt");
        drive(1'b1, 1);
        drive(1'b1, 2);
        drive(1'b1, 1);
        run_seq("rst_mid", "+-+-+-", "11", 0);

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            int r, s;
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                r = $urandom_range(0, 99);
                if (r < 40) s = 0;
                else if (r < 97) s = $urandom_range(1, 2);
                else s = 3;
                drive($urandom_range(0, 99) >= 15, s);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
